// File: rtl/avst_pkg.sv
// Shared definitions for the byte-serial Avalon-ST blocks (summing adder and
// its downstream word assembler).
package avst_pkg;

  localparam int AVST_BYTE_W = 8;
  localparam int SUM_BYTES   = 4;

  typedef enum logic {
    COLLECT,
    DISCARD
  } avst_state_e;

endpackage

// File: rtl/avst_out_reg.sv
// Single-entry valid/ready holding register. A load on the same edge as a
// drain replaces the word and keeps valid high, giving back-to-back throughput.
module avst_out_reg
  import avst_pkg::*;
#(
  parameter int WIDTH = 8 * SUM_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avst_word_assembler.sv
// Reassembles MSB-first Avalon-ST byte packets into words, drops packets of
// the wrong length, and keeps good/error packet counters.
module avst_word_assembler
  import avst_pkg::*;
#(
  parameter int BYTES = SUM_BYTES,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AVST_BYTE_W-1:0]     data_in,
  input  logic                       end_in,
  input  logic                       valid_in,
  output logic                       ready_in,
  output logic [AVST_BYTE_W*BYTES-1:0] word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       len_err,
  output logic [CNT_W-1:0]           good_count,
  output logic [ERR_W-1:0]           err_count
);

  localparam int WORD_W = AVST_BYTE_W * BYTES;
  localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  avst_state_e       state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [WORD_W-1:0] shreg, shreg_d, shifted;
  logic              accept, load, bad_end;

  // A discarded packet never produces a word, so it must not be held off by
  // a stalled output register.
  assign ready_in = (state == DISCARD) || !(word_valid && !word_ready);
  assign accept   = valid_in && ready_in;
  assign shifted  = (shreg << AVST_BYTE_W) | WORD_W'(data_in);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    shreg_d = shreg;
    load    = 1'b0;
    bad_end = 1'b0;
    if (accept) begin
      unique case (state)
        COLLECT: begin
          if (end_in) begin
            idx_d   = '0;
            shreg_d = '0;
            if (idx == LAST_IDX) load    = 1'b1;
            else                 bad_end = 1'b1;
          end else if (idx == LAST_IDX) begin
            state_d = DISCARD;
            idx_d   = '0;
            shreg_d = '0;
          end else begin
            idx_d   = idx + IDX_W'(1);
            shreg_d = shifted;
          end
        end
        DISCARD: begin
          if (end_in) begin
            state_d = COLLECT;
            bad_end = 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      idx        <= '0;
      shreg      <= '0;
      len_err    <= 1'b0;
      good_count <= '0;
      err_count  <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      shreg   <= shreg_d;
      len_err <= bad_end;
      if (load) good_count <= good_count + CNT_W'(1);
      if (bad_end && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

  avst_out_reg #(
    .WIDTH(WORD_W)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(shifted),
    .data     (word_out),
    .valid    (word_valid),
    .ready    (word_ready)
  );

endmodule

// File: tb/tb_avst_word_assembler.sv
// Directed scoreboard bench for avst_word_assembler: expected words are queued
// as packets are sent and compared as the output handshake completes.
module tb_avst_word_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        end_in;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        len_err;
  logic [15:0] good_count;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;
  int stalls;
  int lerr_seen;
  bit acc;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [8:0]  seq_q[$];

  avst_word_assembler dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .end_in    (end_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .len_err   (len_err),
    .good_count(good_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the handshakes of the coming rising edge, then waits for the
  // falling edge after it and records any len_err pulse.
  task automatic tick(output bit accepted);
    #1;
    accepted = valid_in && ready_in;
    if (word_valid && word_ready) obs_q.push_back(word_out);
    @(negedge clk);
    if (len_err) lerr_seen++;
  endtask

  task automatic send_seq();
    stalls = 0;
    while (seq_q.size() > 0) begin
      logic [8:0] b;
      int guard;
      b        = seq_q.pop_front();
      valid_in = 1'b1;
      data_in  = b[7:0];
      end_in   = b[8];
      guard    = 0;
      tick(acc);
      while (!acc && guard < 100) begin
        stalls++;
        guard++;
        tick(acc);
      end
      if (!acc) begin
        check("accept_timeout", 32'(guard), 32'd0);
        seq_q.delete();
      end
    end
    valid_in = 1'b0;
    end_in   = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) seq_q.push_back({(i == 0), w[8*i +: 8]});
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      int guard = 0;
      while (obs_q.size() == 0 && guard < 50) begin
        tick(acc);
        guard++;
      end
      if (obs_q.size() == 0) begin
        check({tag, "_timeout"}, 32'(obs_q.size()), 32'd1);
        exp_q.delete();
      end else begin
        check(tag, obs_q.pop_front(), exp_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    end_in   = 1'b0;
    tick(acc);
    tick(acc);
    reset = 1'b0;
    tick(acc);
    obs_q.delete();
    lerr_seen = 0;
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 8'h00;
    end_in     = 1'b0;
    valid_in   = 1'b0;
    word_ready = 1'b0;
    lerr_seen  = 0;
    tick(acc);
    check("rst_ready_in", 32'(ready_in), 32'd1);
    check("rst_word_out", word_out, 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_good_count", 32'(good_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick(acc);

    // Single packet: word visible right after the end-beat edge, for one cycle.
    word_ready = 1'b1;
    seq_q.push_back({1'b0, 8'h12});
    seq_q.push_back({1'b0, 8'h34});
    seq_q.push_back({1'b0, 8'h56});
    send_seq();
    check("t1_no_early_valid", 32'(word_valid), 32'd0);
    exp_q.push_back(32'h12345678);
    seq_q.push_back({1'b1, 8'h78});
    send_seq();
    check("t1_valid_latency", 32'(word_valid), 32'd1);
    check("t1_word_out", word_out, 32'h12345678);
    check("t1_good_count", 32'(good_count), 32'd1);
    tick(acc);
    check("t1_valid_one_cycle", 32'(word_valid), 32'd0);
    drain("t1_word");

    // Back-to-back packets with no ready_in gap.
    do_reset();
    push_word(32'hDEADBEEF);
    push_word(32'h00000001);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h00000001);
    send_seq();
    check("t2_stalls", 32'(stalls), 32'd0);
    drain("t2_word");
    check("t2_good_count", 32'(good_count), 32'd2);

    // Held word: output stalls and blocks the next packet until drained.
    do_reset();
    word_ready = 1'b0;
    push_word(32'hAABBCCDD);
    exp_q.push_back(32'hAABBCCDD);
    send_seq();
    valid_in = 1'b1;
    data_in  = 8'h55;
    end_in   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(acc);
      check("t3_stall_accept", 32'(acc), 32'd0);
      check("t3_hold_word", word_out, 32'hAABBCCDD);
      check("t3_hold_valid", 32'(word_valid), 32'd1);
    end
    word_ready = 1'b1;
    push_word(32'h55667788);
    exp_q.push_back(32'h55667788);
    send_seq();
    check("t3_release_stalls", 32'(stalls), 32'd0);
    drain("t3_word");
    check("t3_good_count", 32'(good_count), 32'd2);

    // Short packet is dropped; the next packet assembles cleanly.
    do_reset();
    seq_q.push_back({1'b0, 8'h01});
    seq_q.push_back({1'b1, 8'h02});
    send_seq();
    check("t4_len_err", 32'(len_err), 32'd1);
    check("t4_err_count", 32'(err_count), 32'd1);
    check("t4_no_word", 32'(word_valid), 32'd0);
    tick(acc);
    check("t4_len_err_pulse", 32'(len_err), 32'd0);
    push_word(32'h11223344);
    exp_q.push_back(32'h11223344);
    send_seq();
    drain("t4_word");
    check("t4_good_count", 32'(good_count), 32'd1);
    check("t4_err_count_after", 32'(err_count), 32'd1);

    // Long packet: six bytes, all dropped, one len_err at the end beat.
    do_reset();
    for (int i = 0; i < 6; i++) seq_q.push_back({(i == 5), 8'(8'hA0 + i)});
    send_seq();
    check("t5_stalls", 32'(stalls), 32'd0);
    check("t5_len_err_at_end", 32'(len_err), 32'd1);
    tick(acc);
    tick(acc);
    check("t5_len_err_once", 32'(lerr_seen), 32'd1);
    check("t5_err_count", 32'(err_count), 32'd1);
    check("t5_no_word", 32'(obs_q.size()), 32'd0);
    check("t5_good_count", 32'(good_count), 32'd0);
    push_word(32'h01020304);
    exp_q.push_back(32'h01020304);
    send_seq();
    drain("t5_word");

    // Reset mid-packet: partial bytes and counters are lost.
    seq_q.push_back({1'b0, 8'h99});
    seq_q.push_back({1'b0, 8'h88});
    send_seq();
    reset = 1'b1;
    #1;
    check("t6_good_count_rst", 32'(good_count), 32'd0);
    check("t6_err_count_rst", 32'(err_count), 32'd0);
    check("t6_ready_rst", 32'(ready_in), 32'd1);
    check("t6_valid_rst", 32'(word_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(acc);
    push_word(32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    send_seq();
    drain("t6_word");
    check("t6_good_count", 32'(good_count), 32'd1);

    tick(acc);
    tick(acc);
    check("no_spurious_words", 32'(obs_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
